motor_axis_apb_ctrl: RTL and testbench

Parametrised APB3 register block driving N stepper-motor axis cores from the fabric processor. It holds per-axis signed move targets as magnitude plus direction, issues one-cycle start pulses, tracks busy/done per axis and raises a maskable, mode-selectable fabric interrupt. It replaces the fixed two-axis write-only handler with readable status, a go register, write-1-to-clear interrupt state and error responses.

---
 rtl/motor_apb_pkg.sv | 17 +
 rtl/motor_axis_slot.sv | 48 ++++
 rtl/motor_axis_apb_ctrl.sv | 139 +++++++++++++
 tb/tb_motor_axis_apb_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_apb_pkg.sv
// Shared constants for the motor axis APB register block: register offsets and interrupt modes.
package motor_apb_pkg;

   localparam int unsigned N_AXES_MAX = 8;

   localparam logic [7:0] OFF_CTRL     = 8'h20;
   localparam logic [7:0] OFF_GO       = 8'h24;
   localparam logic [7:0] OFF_STATUS   = 8'h28;
   localparam logic [7:0] OFF_IRQ_EN   = 8'h2C;
   localparam logic [7:0] OFF_IRQ_STAT = 8'h30;

   typedef enum logic {
      IRQ_ANY = 1'b0,
      IRQ_ALL = 1'b1
   } irq_mode_e;

endpackage

// File: rtl/motor_axis_slot.sv
// One axis: target magnitude/direction, busy tracking, start pulse and done rising-edge detection.
module motor_axis_slot
   import motor_apb_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             PCLK,
   input  logic             PRESET,
   input  logic             tgt_we,
   input  logic [CNT_W-1:0] tgt_val,
   input  logic             go,
   input  logic             done_in,
   output logic [CNT_W-1:0] cnt_out,
   output logic             dir_out,
   output logic             start,
   output logic             busy,
   output logic             done_evt_c
);

   logic done_q;

   // A done level already high when the move starts has no rising edge, so it is ignored.
   assign done_evt_c = done_in & ~done_q & busy;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt_out <= '0;
         dir_out <= 1'b1;
         start   <= 1'b0;
         busy    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= done_in;
         start  <= go & ~busy;
         if (done_evt_c) begin
            busy <= 1'b0;
         end else if (go) begin
            busy <= 1'b1;
         end
         // Magnitude wraps for the most-negative value: 2^(CNT_W-1) with dir 0.
         if (tgt_we) begin
            dir_out <= ~tgt_val[CNT_W-1];
            cnt_out <= tgt_val[CNT_W-1] ? -tgt_val : tgt_val;
         end
      end
   end

endmodule

// File: rtl/motor_axis_apb_ctrl.sv
// APB3 register block driving N stepper-motor axis cores: targets, go, status and a
// maskable any/all-done fabric interrupt.
module motor_axis_apb_ctrl
   import motor_apb_pkg::*;
#(
   parameter int unsigned N_AXES = 2,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                     PCLK,
   input  logic                     PRESET,
   input  logic                     PSEL,
   input  logic                     PENABLE,
   input  logic                     PWRITE,
   input  logic [31:0]              PADDR,
   input  logic [31:0]              PWDATA,
   output logic [31:0]              PRDATA,
   output logic                     PREADY,
   output logic                     PSLVERR,
   input  logic [N_AXES*CNT_W-1:0]  cnt_in,
   input  logic [N_AXES-1:0]        done_in,
   output logic [N_AXES*CNT_W-1:0]  cnt_out,
   output logic [N_AXES-1:0]        dir_out,
   output logic [N_AXES-1:0]        start,
   output logic                     fabint
);

   logic [7:0]            off;
   logic [2:0]            tgt_idx;
   logic                  access, wr;
   logic                  is_target, tgt_ok, is_ctrl, is_go, is_status, is_en, is_stat, mapped;
   logic                  tgt_busy, go_err;
   logic [CNT_W-1:0]      tgt_rd;
   logic [N_AXES-1:0]     busy, done_evt, tgt_we, go_ok, irq_masked;
   logic [N_AXES_MAX-1:0] busy_ext, done_ext;
   logic [N_AXES-1:0]     irq_en, irq_stat, w1c_mask;
   irq_mode_e             irq_mode;
   logic                  fabint_c;
   logic                  unused_bits;

   assign unused_bits = ^{PADDR[31:8], PADDR[1:0], PWDATA};

   assign off     = {PADDR[7:2], 2'b00};
   assign tgt_idx = PADDR[4:2];
   assign access  = PSEL & PENABLE;
   assign wr      = access & PWRITE;
   assign PREADY  = 1'b1;

   assign is_target = (PADDR[7:5] == 3'b000);
   assign tgt_ok    = is_target & ({29'd0, tgt_idx} < N_AXES);
   assign is_ctrl   = (off == OFF_CTRL);
   assign is_go     = (off == OFF_GO);
   assign is_status = (off == OFF_STATUS);
   assign is_en     = (off == OFF_IRQ_EN);
   assign is_stat   = (off == OFF_IRQ_STAT);
   assign mapped    = tgt_ok | is_ctrl | is_go | is_status | is_en | is_stat;

   // Per-axis select, write enables and zero-extended status vectors.
   always_comb begin
      tgt_busy = 1'b0;
      tgt_rd   = '0;
      tgt_we   = '0;
      go_ok    = '0;
      busy_ext = '0;
      done_ext = '0;
      for (int i = 0; i < N_AXES; i++) begin
         busy_ext[i] = busy[i];
         done_ext[i] = done_in[i];
         if (tgt_ok && (tgt_idx == 3'(i))) begin
            tgt_busy  = busy[i];
            tgt_rd    = cnt_in[i*CNT_W +: CNT_W];
            tgt_we[i] = wr & ~busy[i];
         end
         go_ok[i] = wr & is_go & PWDATA[i] & ~busy[i];
      end
   end

   assign go_err  = is_go & (|(PWDATA[N_AXES-1:0] & busy));
   assign PSLVERR = access & (~mapped | (PWRITE & ((tgt_ok & tgt_busy) | go_err)));

   for (genvar g = 0; g < N_AXES; g++) begin : g_axis
      motor_axis_slot #(.CNT_W(CNT_W)) u_slot (
         .PCLK       (PCLK),
         .PRESET     (PRESET),
         .tgt_we     (tgt_we[g]),
         .tgt_val    (PWDATA[CNT_W-1:0]),
         .go         (go_ok[g]),
         .done_in    (done_in[g]),
         .cnt_out    (cnt_out[g*CNT_W +: CNT_W]),
         .dir_out    (dir_out[g]),
         .start      (start[g]),
         .busy       (busy[g]),
         .done_evt_c (done_evt[g])
      );
   end

   assign w1c_mask = (wr & is_stat) ? PWDATA[N_AXES-1:0] : '0;

   always_comb begin
      irq_masked = irq_stat & irq_en;
      if (irq_mode == IRQ_ALL) begin
         fabint_c = (irq_masked == irq_en) && (irq_en != '0);
      end else begin
         fabint_c = |irq_masked;
      end
   end

   // Done events are OR-ed after the clear so a same-cycle set wins over W1C.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         irq_mode <= IRQ_ANY;
         irq_en   <= '0;
         irq_stat <= '0;
         fabint   <= 1'b0;
      end else begin
         if (wr & is_ctrl) irq_mode <= irq_mode_e'(PWDATA[0]);
         if (wr & is_en)   irq_en   <= PWDATA[N_AXES-1:0];
         irq_stat <= (irq_stat & ~w1c_mask) | done_evt;
         fabint   <= fabint_c;
      end
   end

   always_comb begin
      PRDATA = '0;
      if (PSEL) begin
         if (tgt_ok) begin
            PRDATA = 32'(tgt_rd);
         end else begin
            case (off)
               OFF_CTRL:     PRDATA = 32'(irq_mode);
               OFF_STATUS:   PRDATA = {16'd0, done_ext, busy_ext};
               OFF_IRQ_EN:   PRDATA = 32'(irq_en);
               OFF_IRQ_STAT: PRDATA = 32'(irq_stat);
               default:      PRDATA = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_motor_axis_apb_ctrl.sv
// Self-checking bench for motor_axis_apb_ctrl: randomized targets and IRQ rounds against a register-level model.
module tb_motor_axis_apb_ctrl;

   localparam int unsigned N = 2;
   localparam int unsigned W = 32;

   logic          PCLK = 1'b0;
   logic          PRESET, PSEL, PENABLE, PWRITE;
   logic [31:0]   PADDR, PWDATA, PRDATA;
   logic          PREADY, PSLVERR;
   logic [N*W-1:0] cnt_in, cnt_out;
   logic [N-1:0]  done_in, dir_out, start;
   logic          fabint;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model of the programmer-visible state
   logic [W-1:0] m_cnt [N];
   logic [N-1:0] m_dir, m_busy, m_en, m_stat;
   logic         m_mode;

   logic         err, eerr;
   logic [N-1:0] estart;
   logic [31:0]  rd;

   motor_axis_apb_ctrl #(.N_AXES(N), .CNT_W(W)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .cnt_in(cnt_in), .done_in(done_in), .cnt_out(cnt_out), .dir_out(dir_out),
      .start(start), .fabint(fabint)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   function automatic logic [W-1:0] mag_of(input logic [31:0] d);
      longint v;
      v = longint'($signed(d[W-1:0]));
      if (v < 0) v = -v;
      return W'(v);
   endfunction

   function automatic logic exp_fab();
      if (m_mode) return (m_en != '0) && ((m_stat & m_en) == m_en);
      return |(m_stat & m_en);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_cnt[i] = '0;
      m_dir = '1; m_busy = '0; m_en = '0; m_stat = '0; m_mode = 1'b0;
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                              output logic e, output logic [N-1:0] started);
      int unsigned off, idx;
      off = {24'd0, a[7:2], 2'b00};
      e = 1'b0; started = '0;
      if (off < 32'h20) begin
         idx = off / 4;
         if (idx >= N) e = 1'b1;
         else if (m_busy[idx]) e = 1'b1;
         else begin
            m_cnt[idx] = mag_of(d);
            m_dir[idx] = ($signed(d[W-1:0]) >= 0);
         end
      end else begin
         case (off)
            32'h20: m_mode = d[0];
            32'h24: for (int i = 0; i < N; i++) if (d[i]) begin
                       if (m_busy[i]) e = 1'b1;
                       else begin m_busy[i] = 1'b1; started[i] = 1'b1; end
                    end
            32'h28: ;
            32'h2C: m_en = d[N-1:0];
            32'h30: m_stat = m_stat & ~d[N-1:0];
            default: e = 1'b1;
         endcase
      end
   endtask

   task automatic model_done(input int i);
      if (m_busy[i]) begin m_busy[i] = 1'b0; m_stat[i] = 1'b1; end
   endtask

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      e = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(negedge PCLK);
      d = PRDATA; e = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr_both(input logic [31:0] a, input logic [31:0] d,
                          output logic e, output logic ee, output logic [N-1:0] es);
      model_write(a, d, ee, es);
      apb_write(a, d, e);
   endtask

   task automatic raise_done(input int i);
      @(posedge PCLK); #1;
      done_in[i] = 1'b1;
      model_done(i);
      @(posedge PCLK); #1;
      @(posedge PCLK); #1;
   endtask

   task automatic lower_done();
      @(posedge PCLK); #1;
      done_in = '0;
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      #1 PRESET = 1'b0;
      model_reset();
      n_checks++; if (dir_out !== 2'b11) $display("FAIL reset_dir got %b want 11", dir_out); else n_pass++;
      n_checks++; if (cnt_out !== '0) $display("FAIL reset_cnt got %h want 0", cnt_out); else n_pass++;
      n_checks++; if (fabint !== 1'b0) $display("FAIL reset_fabint got %b want 0", fabint); else n_pass++;
      n_checks++; if (start !== '0) $display("FAIL reset_start got %b want 0", start); else n_pass++;
      n_checks++; if (PREADY !== 1'b1) $display("FAIL pready got %b want 1", PREADY); else n_pass++;
      apb_read(32'h28, rd, err);
      n_checks++; if (rd !== 32'h0) $display("FAIL reset_status got %h want 0", rd); else n_pass++;
      n_checks++; if (PRDATA !== 32'h0) $display("FAIL prdata_idle got %h want 0", PRDATA); else n_pass++;
   endtask

   task automatic test_target();
      logic [31:0] tv [3];
      int          ta [3];
      logic [31:0] d;
      int          ax;
      tv = '{32'hFFFF_FF9C, 32'd250, 32'h8000_0000};
      ta = '{0, 1, 0};
      for (int k = 0; k < 15; k++) begin
         if (k < 3) begin d = tv[k]; ax = ta[k]; end
         else begin d = $urandom; ax = $urandom_range(0, N - 1); end
         wr_both(32'(ax * 4), d, err, eerr, estart);
         n_checks++; if (err !== eerr) $display("FAIL target_err k=%0d got %b want %b", k, err, eerr); else n_pass++;
         for (int i = 0; i < N; i++) begin
            n_checks++;
            if (cnt_out[i*W +: W] !== m_cnt[i])
               $display("FAIL target_cnt k=%0d axis %0d got %h want %h", k, i, cnt_out[i*W +: W], m_cnt[i]);
            else n_pass++;
            n_checks++;
            if (dir_out[i] !== m_dir[i])
               $display("FAIL target_dir k=%0d axis %0d got %b want %b", k, i, dir_out[i], m_dir[i]);
            else n_pass++;
         end
         if (k == 2) begin
            n_checks++; if (cnt_out[W-1:0] !== 32'h8000_0000 || dir_out[0] !== 1'b0)
               $display("FAIL target_minneg got %h/%b want 80000000/0", cnt_out[W-1:0], dir_out[0]); else n_pass++;
            n_checks++; if (cnt_out[2*W-1:W] !== 32'd250 || dir_out[1] !== 1'b1)
               $display("FAIL target_pos got %h/%b want 000000fa/1", cnt_out[2*W-1:W], dir_out[1]); else n_pass++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         cnt_in = {$urandom, $urandom};
         ax = k % N;
         apb_read(32'(ax * 4), rd, err);
         n_checks++; if (rd !== 32'(cnt_in[ax*W +: W]) || err !== 1'b0)
            $display("FAIL target_read axis %0d got %h/%b want %h/0", ax, rd, err, cnt_in[ax*W +: W]); else n_pass++;
      end
   endtask

   task automatic test_go_irq_any();
      wr_both(32'h2C, 32'd3, err, eerr, estart);
      wr_both(32'h20, 32'd0, err, eerr, estart);
      wr_both(32'h24, 32'd3, err, eerr, estart);
      n_checks++; if (start !== estart) $display("FAIL go_start got %b want %b", start, estart); else n_pass++;
      @(posedge PCLK); #1;
      n_checks++; if (start !== 2'b00) $display("FAIL go_start_width got %b want 00", start); else n_pass++;
      apb_read(32'h28, rd, err);
      n_checks++; if (rd !== 32'h0000_0003) $display("FAIL go_busy got %h want 00000003", rd); else n_pass++;
      @(posedge PCLK); #1;
      done_in[0] = 1'b1;
      model_done(0);
      @(posedge PCLK); #1;
      n_checks++; if (fabint !== 1'b0) $display("FAIL fabint_latency got %b want 0", fabint); else n_pass++;
      @(posedge PCLK); #1;
      n_checks++; if (fabint !== exp_fab()) $display("FAIL fabint_any got %b want %b", fabint, exp_fab()); else n_pass++;
      apb_read(32'h30, rd, err);
      n_checks++; if (rd !== 32'(m_stat)) $display("FAIL irq_stat got %h want %h", rd, m_stat); else n_pass++;
      apb_read(32'h28, rd, err);
      n_checks++; if (rd !== 32'h0000_0102) $display("FAIL status_done got %h want 00000102", rd); else n_pass++;
      wr_both(32'h30, 32'd1, err, eerr, estart);
      @(posedge PCLK); #1;
      n_checks++; if (fabint !== 1'b0) $display("FAIL w1c_fabint got %b want 0", fabint); else n_pass++;
      raise_done(1);
      n_checks++; if (fabint !== 1'b1) $display("FAIL fabint_axis1 got %b want 1", fabint); else n_pass++;
      wr_both(32'h30, 32'd3, err, eerr, estart);
      lower_done();
   endtask

   task automatic test_irq_all();
      wr_both(32'h20, 32'd1, err, eerr, estart);
      wr_both(32'h2C, 32'd3, err, eerr, estart);
      wr_both(32'h24, 32'd3, err, eerr, estart);
      raise_done(0);
      repeat (2) @(posedge PCLK);
      #1;
      n_checks++; if (fabint !== 1'b0) $display("FAIL all_partial got %b want 0", fabint); else n_pass++;
      raise_done(1);
      n_checks++; if (fabint !== 1'b1) $display("FAIL all_full got %b want 1", fabint); else n_pass++;
      wr_both(32'h30, 32'd3, err, eerr, estart);
      @(posedge PCLK); #1;
      n_checks++; if (fabint !== 1'b0) $display("FAIL all_clear got %b want 0", fabint); else n_pass++;
      lower_done();
   endtask

   task automatic test_errors();
      wr_both(32'h24, 32'd1, err, eerr, estart);
      wr_both(32'h00, 32'h0000_1234, err, eerr, estart);
      n_checks++; if (err !== eerr) $display("FAIL busy_target_err got %b want %b", err, eerr); else n_pass++;
      n_checks++; if (cnt_out[W-1:0] !== m_cnt[0]) $display("FAIL busy_target_cnt got %h want %h", cnt_out[W-1:0], m_cnt[0]); else n_pass++;
      wr_both(32'h24, 32'd1, err, eerr, estart);
      n_checks++; if (err !== 1'b1 || start !== estart) $display("FAIL busy_go got err %b start %b want 1/%b", err, start, estart); else n_pass++;
      wr_both(32'h24, 32'd3, err, eerr, estart);
      n_checks++; if (err !== 1'b1 || start !== 2'b10) $display("FAIL partial_go got err %b start %b want 1/10", err, start); else n_pass++;
      apb_read(32'h3C, rd, err);
      n_checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL unmapped got err %b data %h want 1/0", err, rd); else n_pass++;
      apb_read(32'h08, rd, err);
      n_checks++; if (err !== 1'b1 || rd !== 32'h0) $display("FAIL target_oob got err %b data %h want 1/0", err, rd); else n_pass++;
      apb_read(32'h24, rd, err);
      n_checks++; if (err !== 1'b0 || rd !== 32'h0) $display("FAIL go_read got err %b data %h want 0/0", err, rd); else n_pass++;
      @(posedge PCLK); #1;
      done_in = 2'b11;
      model_done(0); model_done(1);
      repeat (2) @(posedge PCLK);
      #1;
      apb_read(32'h28, rd, err);
      n_checks++; if (rd[7:0] !== 8'(m_busy)) $display("FAIL err_busy_clear got %h want %h", rd[7:0], m_busy); else n_pass++;
      wr_both(32'h30, 32'd3, err, eerr, estart);
      lower_done();
   endtask

   task automatic test_same_cycle();
      wr_both(32'h24, 32'd1, err, eerr, estart);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30; PWDATA = 32'd1;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; done_in[0] = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      m_stat[0] = 1'b0; model_done(0);
      apb_read(32'h30, rd, err);
      n_checks++; if (rd !== 32'(m_stat)) $display("FAIL w1c_vs_set got %h want %h", rd, m_stat); else n_pass++;
      wr_both(32'h30, 32'd3, err, eerr, estart);
      lower_done();
      wr_both(32'h24, 32'd1, err, eerr, estart);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h24; PWDATA = 32'd1;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; done_in[0] = 1'b1;
      @(negedge PCLK);
      err = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      model_done(0);
      n_checks++; if (err !== 1'b1 || start !== 2'b00) $display("FAIL go_vs_done got err %b start %b want 1/00", err, start); else n_pass++;
      apb_read(32'h28, rd, err);
      n_checks++; if (rd[7:0] !== 8'(m_busy)) $display("FAIL go_vs_done_busy got %h want %h", rd[7:0], m_busy); else n_pass++;
      wr_both(32'h30, 32'd3, err, eerr, estart);
      lower_done();
   endtask

   task automatic test_reset_mid_move();
      int seen;
      seen = 0;
      wr_both(32'h2C, 32'd3, err, eerr, estart);
      wr_both(32'h24, 32'd3, err, eerr, estart);
      @(posedge PCLK); #1;
      PRESET = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge PCLK); #1;
         if (c == 1) PRESET = 1'b0;
         if (start !== 2'b00) seen++;
      end
      model_reset();
      n_checks++; if (seen !== 0) $display("FAIL reset_start_pulses got %0d want 0", seen); else n_pass++;
      apb_read(32'h28, rd, err);
      n_checks++; if (rd !== 32'h0) $display("FAIL reset_busy got %h want 0", rd); else n_pass++;
      raise_done(0);
      apb_read(32'h30, rd, err);
      n_checks++; if (rd !== 32'(m_stat)) $display("FAIL reset_no_event got %h want %h", rd, m_stat); else n_pass++;
      n_checks++; if (dir_out !== m_dir) $display("FAIL reset_dir2 got %b want %b", dir_out, m_dir); else n_pass++;
      lower_done();
   endtask

   task automatic test_random_irq();
      logic [N-1:0] en;
      logic         mode;
      int           first;
      for (int r = 0; r < 8; r++) begin
         en    = N'($urandom_range(1, 3));
         mode  = 1'($urandom_range(0, 1));
         first = $urandom_range(0, 1);
         wr_both(32'h20, {31'd0, mode}, err, eerr, estart);
         wr_both(32'h2C, 32'(en), err, eerr, estart);
         wr_both(32'h30, 32'd3, err, eerr, estart);
         wr_both(32'h24, 32'd3, err, eerr, estart);
         n_checks++; if (start !== estart) $display("FAIL rnd_start r=%0d got %b want %b", r, start, estart); else n_pass++;
         raise_done(first);
         n_checks++; if (fabint !== exp_fab()) $display("FAIL rnd_fab1 r=%0d got %b want %b", r, fabint, exp_fab()); else n_pass++;
         raise_done(1 - first);
         n_checks++; if (fabint !== exp_fab()) $display("FAIL rnd_fab2 r=%0d got %b want %b", r, fabint, exp_fab()); else n_pass++;
         apb_read(32'h30, rd, err);
         n_checks++; if (rd !== 32'(m_stat)) $display("FAIL rnd_stat r=%0d got %h want %h", r, rd, m_stat); else n_pass++;
         lower_done();
      end
   endtask

   initial begin
      PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; cnt_in = '0; done_in = '0;
      model_reset();
      test_reset();
      test_target();
      test_go_irq_any();
      test_irq_all();
      test_errors();
      test_same_cycle();
      test_reset_mid_move();
      test_random_irq();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
